// File: rtl/div_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// Holds the FSM state encoding and the default counter width.
package div_mon_pkg;

    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        MEAS   = 2'd2,
        LOCKED = 2'd3
    } div_mon_state_t;

endpackage

// File: rtl/div_edge_sync.sv
// Two-flop synchronizer followed by a history flop.
// Produces the synchronized level and single-cycle rise/fall strobes.
module div_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock in clk cycles,
// declares lock on a stable ratio and flags a stalled divider.
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout_err
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_CNT);

    div_mon_state_t   state;
    div_mon_state_t   state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_nxt;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic             timeout_hit;
    logic             lvl;
    logic             rise;
    logic             fall;

    div_edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (div_in),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    // A rise always beats a saturated counter, so a max-length period is measured, not timed out.
    always_comb begin
        state_nxt   = state;
        match_nxt   = match_cnt;
        period_nxt  = period;
        high_nxt    = high_time;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout_err;
        timeout_hit = (cnt == CNT_MAX) && !rise;

        if (rise) begin
            cnt_nxt = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
        end else begin
            cnt_nxt = cnt;
        end

        if (rise) begin
            hcnt_nxt = CNT_ONE;
        end else if (lvl && (hcnt != CNT_MAX)) begin
            hcnt_nxt = hcnt + CNT_ONE;
        end else begin
            hcnt_nxt = hcnt;
        end

        unique case (state)
            IDLE: begin
                state_nxt = ACQ;
            end
            ACQ: begin
                if (rise) begin
                    state_nxt = MEAS;
                end
            end
            MEAS, LOCKED: begin
                // Falls seen before the first rise belong to a partial phase, hence only here.
                if (fall) begin
                    high_nxt = hcnt;
                end
                if (rise) begin
                    period_nxt = cnt;
                    valid_nxt  = 1'b1;
                    if (cnt == period) begin
                        if (match_cnt != LOCK_VAL) begin
                            match_nxt = match_cnt + MW'(1);
                        end
                    end else begin
                        match_nxt = '0;
                    end
                    state_nxt = (match_nxt == LOCK_VAL) ? LOCKED : MEAS;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if ((state != IDLE) && timeout_hit) begin
            timeout_nxt = 1'b1;
            match_nxt   = '0;
            state_nxt   = ACQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            match_cnt    <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (!en) begin
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            match_cnt    <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hcnt         <= hcnt_nxt;
            match_cnt    <= match_nxt;
            period       <= period_nxt;
            high_time    <= high_nxt;
            period_valid <= valid_nxt;
            locked       <= (state_nxt == LOCKED);
            timeout_err  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor: table-driven divided-clock
// streams plus hand-written stall, enable-drop and async-reset sequences.
module tb_div_clk_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic       div_in;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       period_valid;
    logic       locked;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_pv_cyc = 0;

    typedef struct {
        int          hi;
        int          lo;
        int          nper;
        int          npulse;
        int          first_period;
        int          first_high;
        int          per;
        int          high;
        logic [15:0] lock_mask;
    } row_t;

    row_t rows[6];

    div_clk_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div_in       (div_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, " period"}, period, 0);
        check_output({tag, " high_time"}, high_time, 0);
        check_output({tag, " period_valid"}, period_valid, 0);
        check_output({tag, " locked"}, locked, 0);
        check_output({tag, " timeout_err"}, timeout_err, 0);
    endtask

    // Drives nper periods of hi/lo and checks every period_valid pulse against the row.
    task automatic apply_stimulus(input row_t r, input string tag);
        int pulses = 0;
        for (int p = 0; p < r.nper; p++) begin
            for (int c = 0; c < r.hi + r.lo; c++) begin
                @(negedge clk);
                div_in = (c < r.hi);
                @(posedge clk);
                #1;
                if (period_valid) begin
                    pulses++;
                    last_pv_cyc = cyc;
                    check_output($sformatf("%s pulse%0d period", tag, pulses), period,
                                 (pulses == 1) ? r.first_period : r.per);
                    check_output($sformatf("%s pulse%0d high_time", tag, pulses), high_time,
                                 (pulses == 1) ? r.first_high : r.high);
                    if (pulses <= 16) begin
                        check_output($sformatf("%s pulse%0d locked", tag, pulses), locked,
                                     int'(r.lock_mask[pulses-1]));
                    end
                    check_output($sformatf("%s pulse%0d timeout_err", tag, pulses), timeout_err, 0);
                end
            end
        end
        check_output({tag, " pulse_count"}, pulses, r.npulse);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            div_in = 1'b0;
        end
    endtask

    initial begin
        bit early;

        rows[0] = '{hi: 4, lo: 4, nper: 6, npulse: 5, first_period: 8, first_high: 4, per: 8, high: 4, lock_mask: 16'h0010};
        rows[1] = '{hi: 3, lo: 3, nper: 7, npulse: 7, first_period: 8, first_high: 4, per: 6, high: 3, lock_mask: 16'h0061};
        rows[2] = '{hi: 1, lo: 2, nper: 7, npulse: 7, first_period: 6, first_high: 3, per: 3, high: 1, lock_mask: 16'h0061};
        rows[3] = '{hi: 4, lo: 4, nper: 6, npulse: 5, first_period: 8, first_high: 4, per: 8, high: 4, lock_mask: 16'h0010};
        rows[4] = '{hi: 4, lo: 4, nper: 6, npulse: 5, first_period: 8, first_high: 4, per: 8, high: 4, lock_mask: 16'h0010};
        rows[5] = '{hi: 3, lo: 3, nper: 6, npulse: 5, first_period: 6, first_high: 3, per: 6, high: 3, lock_mask: 16'h0010};

        rst    = 1'b0;
        en     = 1'b0;
        div_in = 1'b0;
        #2;
        check_zero("reset");

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        idle_cycles(4);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(rows[i], $sformatf("row%0d", i));
        end

        // Stall: input held low after lock must time out exactly 255 cycles after the last rise.
        div_in = 1'b0;
        early  = 1'b0;
        while (cyc < last_pv_cyc + 254) begin
            @(posedge clk);
            #1;
            if (timeout_err || !locked) early = 1'b1;
        end
        check_output("stall early_timeout", int'(early), 0);
        check_output("stall pre timeout_err", timeout_err, 0);
        check_output("stall pre locked", locked, 1);
        @(posedge clk);
        #1;
        check_output("stall timeout_err", timeout_err, 1);
        check_output("stall locked", locked, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        check_output("stall sticky timeout_err", timeout_err, 1);
        check_output("stall held period", period, 3);

        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check_zero("en_drop_after_stall");
        @(negedge clk);
        en = 1'b1;
        idle_cycles(4);
        apply_stimulus(rows[3], "row3");

        // Enable drop in the middle of a high phase, with a rise in flight.
        @(negedge clk);
        div_in = 1'b1;
        @(negedge clk);
        div_in = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check_zero("en_drop_mid");
        @(negedge clk);
        div_in = 1'b0;
        en     = 1'b1;
        idle_cycles(4);
        apply_stimulus(rows[4], "row4");

        // Asynchronous reset asserted between clock edges while locked.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(4);
        apply_stimulus(rows[5], "row5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Receiving-side companion to the team's clock frequency divider. It samples a divided clock and measures its period and high time in `clk` cycles. It declares lock once the ratio is stable and flags a stalled divider. It sits wherever a divided clock is consumed and its ratio and health must be checked at run time, such as a self-test or a clock-health status register.

## Interface

Parameters:
- `CNT_W`, default 8: width of the period and high-time counters; the maximum measurable period is 2^CNT_W−1.
- `LOCK_CNT`, default 4: number of consecutive matching periods required to assert `locked`.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: monitor enable. When low, the block is held cleared synchronously.
- `div_in`, in, 1: the divided clock under test, sampled as data.
- `period`, out, CNT_W: last measured rising-to-rising period, in `clk` cycles.
- `high_time`, out, CNT_W: last measured high phase, in `clk` cycles.
- `period_valid`, out, 1: one-cycle pulse when `period` updates.
- `locked`, out, 1: period has been stable for LOCK_CNT consecutive matches.
- `timeout_err`, out, 1: sticky flag for a missing edge.

## Operation

- **Input path:** 2-flop synchronizer `s1`/`s2`, then a history flop `s3`. `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- **Period counter `cnt`:**
  - On `rise`, `cnt <= 1`.
  - Otherwise `cnt <= cnt + 1`, saturating at 2^CNT_W−1.
- **High counter `hcnt`:**
  - On `rise`, `hcnt <= 1`.
  - While `s2` is high with no `rise`, `hcnt` increments (saturating).
  - On `fall`, `high_time <= hcnt`.
- **FSM states:** IDLE, ACQ, MEAS, LOCKED.
  - IDLE: entered on reset or whenever `en = 0`. If `en = 1`, go to ACQ.
  - ACQ: the first `rise` only starts `cnt`, because the preceding period is partial. No `period_valid`. Go to MEAS.
  - MEAS: each `rise` does `period <= cnt` and pulses `period_valid`.
    - If the new value equals the previous `period`, `match_cnt++`; otherwise `match_cnt <= 0`.
    - When `match_cnt` reaches LOCK_CNT, go to LOCKED.
  - LOCKED: same measurement. A mismatch sets `match_cnt <= 0` and returns to MEAS.
- **`locked`:** registered and equal to (state == LOCKED).
- **Timeout:** in ACQ, MEAS or LOCKED, if `cnt` equals its maximum and there is no `rise` that cycle:
  - `timeout_err <= 1`, sticky until `en = 0` or reset.
  - `match_cnt <= 0`; state goes to ACQ.
- **Simultaneous events:**
  - `rise` together with a saturated `cnt`: the rise wins, `period` = max, `period_valid` pulses, no timeout.
  - `rise` together with `fall` is impossible (single bit).
- **`en = 0`, any state:** on the next edge all outputs, `cnt`, `hcnt` and `match_cnt` go to 0 and state goes to IDLE. The synchronizer flops keep sampling.
- **Arithmetic:** all counters are unsigned CNT_W, saturating, never wrapping. `match_cnt` is `$clog2(LOCK_CNT+1)` bits wide.
- **Supported input:** period ≥ 2 cycles and phases ≥ 1 cycle, driven synchronously to `clk` or slower.

## Timing

- **Reset values:** all outputs are 0 (`period`, `high_time`, `period_valid`, `locked`, `timeout_err`). State is IDLE. Reset takes effect immediately, with no clock edge required.
- **Latency:** `div_in` rising before edge k gives `rise` in cycle k+2. `period`/`period_valid` update at edge k+3, and `high_time` updates likewise after a fall.
- **Lock latency:** `locked` rises on the same edge as the (LOCK_CNT+1)-th `period_valid` after acquisition. It falls on the edge of the mismatching `period_valid`.
- **Timeout:** `timeout_err` rises 2^CNT_W−1 cycles after the last `rise`, or after entering ACQ.

## Structure

- Shared package `div_mon_pkg`: state enum `div_mon_state_t` (IDLE/ACQ/MEAS/LOCKED) and the default `CNT_W` constant.
- Sub-module `div_edge_sync`: 2-flop synchronizer plus history flop. Inputs are `clk`, `rst` and `d`; outputs are `lvl`, `rise` and `fall`.
- Top level: counters, comparator and FSM.

## Test plan

- **Divide-by-8 stream:** `div_in` 4 high / 4 low, `en = 1`, defaults → `period_valid` every 8 cycles with `period = 8`, `high_time = 4`. `locked` = 1 at the 5th `period_valid`.
- **Ratio change while locked:** switch `div_in` to 3 high / 3 low → next pulse gives `period = 6`, `high_time = 3`, `locked` drops on that edge. Relock at the 5th pulse of 6.
- **Stalled input:** hold `div_in` low after lock → `timeout_err = 1` and `locked = 0` exactly 255 cycles after the last `rise`. The flag stays set through later edges until `en = 0`.
- **Enable drop mid-period:** drop `en` → the next edge zeroes all outputs. After re-enable, the first rise gives no `period_valid` and the second rise gives a correct `period`.
- **Async reset while locked:** assert `rst = 0` mid-cycle → all outputs are 0 before the next `clk` edge. Lock re-acquires normally after release.
- **Minimum-width pulse:** 1 high / 2 low → `period = 3`, `high_time = 1`, lock after 5 pulses.
